// File: rtl/arith_pkg.sv
// Shared types for the ALU mult/div unit: divider state encoding and result constants.
package arith_pkg;

   localparam int WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } div_state_e;

   // Divide-by-zero quotient is this bit replicated across the full width (all ones).
   localparam logic DIV0_QUOT_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into R, subtract D if it fits.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH:0]   r_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] r_shift;
   logic [WIDTH:0] r_diff;
   logic           fits;

   always_comb begin
      r_shift = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
      r_diff  = r_shift - {1'b0, d_i};
      fits    = (r_shift >= {1'b0, d_i});
      r_o     = fits ? r_diff : r_shift;
      q_o     = {q_i[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/divider_iterative.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU: one restoring step per clock, fixed latency.
module divider_iterative
   import arith_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             valid_out,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             valid_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;

   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q;
   logic             neg_quot_q;
   logic             neg_rem_q;
   logic             dbz_q;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
      return neg ? (~x + 1'b1) : x;
   endfunction

   div_step #(.WIDTH(WIDTH)) u_step (
      .r_i (r_q),
      .q_i (q_q),
      .d_i (d_q),
      .r_o (r_d),
      .q_o (q_d)
   );

   // Divide-by-zero leaves |dividend| in R, and the dividend-sign fix-up restores the raw
   // dividend, so only the quotient needs overriding.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            RUN: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state_q <= FIX;
            end
            FIX: begin
               quot_q  <= dbz_q ? {WIDTH{DIV0_QUOT_FILL}} : cond_neg(q_q, neg_quot_q);
               rem_q   <= cond_neg(r_q[WIDTH-1:0], neg_rem_q);
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: ;
         endcase
         // A new start always wins, restarting RUN and overlapping a completing FIX.
         if (valid_in) begin
            r_q        <= '0;
            q_q        <= cond_neg(dividend, is_signed & dividend[WIDTH-1]);
            d_q        <= cond_neg(divisor, is_signed & divisor[WIDTH-1]);
            neg_quot_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q  <= is_signed & dividend[WIDTH-1];
            dbz_q      <= (divisor == '0);
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
         end
      end
   end

   assign busy      = busy_q;
   assign valid_out = valid_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Scoreboard bench for divider_iterative: directed DIV/DIVU cases, restarts, reset abort, random ops.
module tb_divider_iterative;

   localparam int W   = 32;
   localparam int LAT = 33;

   logic         clk = 1'b0;
   logic         reset;
   logic         valid_in;
   logic         is_signed;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         valid_out;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;

   typedef struct {
      string        tag;
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   divider_iterative #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .valid_out (valid_out),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Reference model: truncating division, remainder follows the dividend sign.
   task automatic model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r);
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = '0;
      end else if (sgn) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic start(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit expect_out,
                        input logic [W-1:0] eq, input logic [W-1:0] er);
      exp_t e;
      valid_in  = 1'b1;
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      if (expect_out) begin
         e.tag = tag;
         e.q   = eq;
         e.r   = er;
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("done_timeout", {31'd0, busy}, '0);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (valid_out) begin
         if (sb.size() == 0) begin
            check("spurious_valid_out", {31'd0, valid_out}, '0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_quot"}, quotient, e.q);
            check({e.tag, "_rem"}, remainder, e.r);
            check({e.tag, "_lat"}, W'(cyc - e.acc), W'(LAT));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb, mq, mr;
      logic         rs;
      int           nb;

      reset = 1'b1; valid_in = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, '0);
      check("rst_valid", {31'd0, valid_out}, '0);
      check("rst_quot", quotient, '0);
      check("rst_rem", remainder, '0);
      reset = 1'b0;
      @(negedge clk);

      // 100 / 7 unsigned with busy-length measurement
      start("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
      nb = 0;
      while (busy && nb < 100) begin
         nb++;
         @(negedge clk);
      end
      check("busy_cycles", W'(nb), W'(LAT));
      @(negedge clk);

      start("div_m7_2", 1'b1, -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      wait_done();
      start("div_7_m2", 1'b1, 32'd7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 32'd1);
      wait_done();
      start("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
      wait_done();
      start("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0);
      wait_done();
      start("divu_dbz", 1'b0, 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234);
      wait_done();
      start("div_dbz", 1'b1, 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234);
      wait_done();
      start("div_dbz_neg", 1'b1, 32'hFFFF_FF00, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00);
      wait_done();

      // Restart mid-run: only the second operation may complete
      start("aborted", 1'b0, 32'd100, 32'd7, 1'b0, '0, '0);
      repeat (9) @(negedge clk);
      start("restart_50_5", 1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0);
      wait_done();

      // New start on the FIX edge: both results are emitted
      start("fix_old", 1'b0, 32'd1000, 32'd9, 1'b1, 32'd111, 32'd1);
      repeat (LAT - 1) @(negedge clk);
      start("fix_new", 1'b1, -32'sd1000, 32'd9, 1'b1, 32'hFFFF_FF91, 32'hFFFF_FFFF);
      wait_done();

      // Reset aborts an operation at cycle 20
      start("rst_abort", 1'b0, 32'd12345, 32'd11, 1'b0, '0, '0);
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, '0);
      check("abort_valid", {31'd0, valid_out}, '0);
      check("abort_quot", quotient, '0);
      check("abort_rem", remainder, '0);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      check("abort_idle_busy", {31'd0, busy}, '0);

      for (int i = 0; i < 10; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = (i < 5) ? W'($urandom_range(1, 300)) : $urandom;
         if (i == 3) rb = -32'sd5;
         model(rs, ra, rb, mq, mr);
         start($sformatf("rand%0d", i), rs, ra, rb, 1'b1, mq, mr);
         wait_done();
      end

      repeat (5) @(negedge clk);
      check("sb_empty", W'(sb.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/divider_iterative.md
Name: divider_iterative

Overview:
- Multi-cycle integer divider; the inverse datapath of the shift-add iterative multiplier in the ALU's mult/div unit.
- Serves MIPS DIV/DIVU: signed or unsigned 32-bit quotient and remainder, one restoring-division step per cycle.
- Shares the same valid_in/valid_out pulse handshake as the multiplier so the HI/LO write-back logic drives both identically.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- valid_in  input  1  single-cycle start pulse; operands sampled on the same edge
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with valid_in
- dividend  input  WIDTH  numerator
- divisor  input  WIDTH  denominator
- busy  output  1  high from the accept edge until the edge that raises valid_out
- valid_out  output  1  one-cycle pulse: quotient/remainder valid
- quotient  output  WIDTH  registered result; held until the next completion
- remainder  output  WIDTH  registered result; held until the next completion

Behaviour:
- Reset, sampled on a clk edge, has priority over everything. Result: state IDLE, busy=0, valid_out=0, quotient=0, remainder=0, counter=0. Reset mid-operation aborts the division; no valid_out follows.
- States:
  - IDLE: on valid_in, load magnitudes, latch sign flags and div-by-zero flag, counter=0, go to RUN.
  - RUN: one restoring step per edge, counter++. After the step with counter==WIDTH-1, go to FIX.
  - FIX: apply sign fix-up, write quotient/remainder, valid_out=1 for exactly one cycle, go to IDLE.
- Latency: accept edge E0; steps on E1..E32; results and valid_out registered on E33 (WIDTH+1 edges). valid_out is visible during the cycle following E33. Fixed latency, no early-out.
- valid_in while busy (RUN or FIX) restarts: the in-flight operation is discarded, the new operands are loaded, and no valid_out is produced for the old one. valid_in on the same edge the FIX state completes: the old result is still emitted, and the new operation is accepted on that edge.
- Restoring step:
  - Partial remainder R has WIDTH+1 bits; Q shifts left, taking dividend magnitude MSB-first.
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - If R' >= D: R = R' - D and quotient bit = 1. Otherwise R = R' and quotient bit = 0.
- Signed mode:
  - Divide magnitudes.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Identity: dividend = quotient*divisor + remainder, with |remainder| < |divisor|.
- Overflow: -2^(WIDTH-1) / -1 gives quotient = 0x80000000, remainder = 0. This falls out naturally; no special case.
- Divide by zero (either mode): quotient = all ones, remainder = the raw dividend input. Same latency; no exception output.
- Unsigned mode: operands are used as-is; no fix-up.
- quotient/remainder change only in the FIX cycle or on reset.

Decomposition:
- Shared package (arith_pkg, alongside the multiplier's types) holds:
  - the state enum typedef (IDLE, RUN, FIX)
  - the WIDTH default constant
  - the divide-by-zero result constant
- One natural combinational sub-module, div_step: input R, Q, D; output next R and Q. Instantiated once, so a radix-4 variant can later swap in two steps.

Test Plan:
- Unsigned 100 / 7 (DIVU), pulse valid_in -> valid_out exactly 33 cycles later, quotient=14, remainder=2; busy high for those 33 edges.
- Signed -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7 / -2 -> quotient=-3, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- Divide by zero: 0x1234 / 0, both modes -> quotient=0xFFFFFFFF, remainder=0x1234, normal latency.
- Start 100/7, then at cycle 10 pulse valid_in with 50/5 -> a single valid_out 33 cycles after the second pulse, quotient=10, remainder=0; no output for 100/7.
- Reset asserted at cycle 20 of an operation -> next edge busy=0, valid_out=0, quotient=remainder=0; no valid_out appears afterwards until a new valid_in.
